// File: rtl/OoO_pkg.sv
// Shared AXI channel structs, burst encodings and FSM state types for the memory responder.
package OoO_pkg;

  localparam logic [31:0] RstAddr = 32'h0000_1000;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } axi_r_s2m_t;

  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
  } axi_w_m2s_t;

  typedef struct packed {
    logic awready;
    logic wready;
    logic bvalid;
  } axi_w_s2m_t;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // WRAP is deliberately handled like INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == BurstFixed) ? addr : addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-wide storage with one byte-strobed write port and one combinational read port.
module axi_mem_array #(
  parameter int unsigned Words = 1024,
  parameter int unsigned IdxW  = (Words > 1) ? $clog2(Words) : 1
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] waddr_i,
  input  logic [31:0]     wdata_i,
  input  logic [3:0]      wstrb_i,
  input  logic [IdxW-1:0] raddr_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [Words];

  // Contents are intentionally never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI slave backed by a word memory; independent read and write FSMs, fixed read latency.
module axi_mem_responder
  import OoO_pkg::*;
#(
  parameter int unsigned MemWords    = 1024,
  parameter logic [31:0] BaseAddr    = RstAddr,
  parameter int unsigned RespLatency = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  axi_r_m2s_t r_m2s_i,
  output axi_r_s2m_t r_s2m_o,
  input  axi_w_m2s_t w_m2s_i,
  output axi_w_s2m_t w_s2m_o
);

  localparam int unsigned IdxW    = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam logic [3:0]  LatLast = 4'((RespLatency >= 2) ? RespLatency - 2 : 0);

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BaseAddr;
    return (a >= BaseAddr) && ((off >> 2) < 32'(MemWords));
  endfunction

  function automatic logic [IdxW-1:0] to_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BaseAddr;
    return off[IdxW+1:2];
  endfunction

  r_state_e    r_state_q, r_state_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [7:0]  r_len_q, r_len_d;
  logic [2:0]  r_size_q, r_size_d;
  logic [1:0]  r_burst_q, r_burst_d;
  logic [7:0]  r_cnt_q, r_cnt_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;

  w_state_e    w_state_q, w_state_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [7:0]  w_len_q, w_len_d;
  logic [2:0]  w_size_q, w_size_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [7:0]  w_cnt_q, w_cnt_d;

  logic        mem_we;
  logic [31:0] mem_rdata;

  axi_mem_array #(
    .Words (MemWords),
    .IdxW  (IdxW)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (mem_we),
    .waddr_i (to_idx(w_addr_q)),
    .wdata_i (w_m2s_i.wdata),
    .wstrb_i (w_m2s_i.wstrb),
    .raddr_i (to_idx(r_addr_q)),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      lat_cnt_q <= '0;
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    lat_cnt_d = lat_cnt_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (r_m2s_i.arvalid) begin
          r_addr_d  = r_m2s_i.araddr;
          r_len_d   = r_m2s_i.arlen;
          r_size_d  = r_m2s_i.arsize;
          r_burst_d = r_m2s_i.arburst;
          r_cnt_d   = '0;
          lat_cnt_d = '0;
          // A latency of one skips the wait state entirely.
          r_state_d = (RespLatency <= 1) ? R_BURST : R_WAIT;
        end
      end
      R_WAIT: begin
        if (lat_cnt_q == LatLast) r_state_d = R_BURST;
        else                      lat_cnt_d = lat_cnt_q + 4'd1;
      end
      R_BURST: begin
        if (r_m2s_i.rready) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d  = r_cnt_q + 8'd1;
            r_addr_d = next_addr(r_addr_q, r_size_q, r_burst_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    r_s2m_o = '0;
    unique case (r_state_q)
      R_IDLE:  r_s2m_o.arready = 1'b1;
      R_BURST: begin
        r_s2m_o.rvalid = 1'b1;
        r_s2m_o.rdata  = in_range(r_addr_q) ? mem_rdata : 32'h0;
        r_s2m_o.rlast  = (r_cnt_q == r_len_q);
      end
      default: r_s2m_o = '0;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (w_m2s_i.awvalid) begin
          w_addr_d  = w_m2s_i.awaddr;
          w_len_d   = w_m2s_i.awlen;
          w_size_d  = w_m2s_i.awsize;
          w_burst_d = w_m2s_i.awburst;
          w_cnt_d   = '0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        // Burst length comes from awlen alone; wlast is not consulted.
        if (w_m2s_i.wvalid) begin
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d  = w_cnt_q + 8'd1;
            w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
          end
        end
      end
      W_RESP:  if (w_m2s_i.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    w_s2m_o = '0;
    mem_we  = 1'b0;
    unique case (w_state_q)
      W_IDLE: w_s2m_o.awready = 1'b1;
      W_DATA: begin
        w_s2m_o.wready = 1'b1;
        mem_we         = w_m2s_i.wvalid && in_range(w_addr_q) && !reset;
      end
      W_RESP:  w_s2m_o.bvalid = 1'b1;
      default: w_s2m_o = '0;
    endcase
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed scoreboard bench for axi_mem_responder: R beats and B responses checked by monitors.
module tb_axi_mem_responder;
  import OoO_pkg::*;

  localparam int unsigned Words   = 16;
  localparam int unsigned RespLat = 2;
  localparam logic [31:0] Base    = RstAddr;

  logic       clock;
  logic       reset;
  axi_r_m2s_t r_m2s;
  axi_r_s2m_t r_s2m;
  axi_w_m2s_t w_m2s;
  axi_w_s2m_t w_s2m;

  int total;
  int bad;

  logic [32:0] rq[$];
  bit          bq[$];
  logic [31:0] wdat [8];
  logic [3:0]  wstb [8];

  axi_mem_responder #(
    .MemWords    (Words),
    .BaseAddr    (Base),
    .RespLatency (RespLat)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .r_m2s_i (r_m2s),
    .r_s2m_o (r_s2m),
    .w_m2s_i (w_m2s),
    .w_s2m_o (w_s2m)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // R monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && r_s2m.rvalid && r_m2s.rready) begin
      logic [32:0] e;
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL r_beat actual=%h/%b required=no beat", r_s2m.rdata, r_s2m.rlast);
      end else begin
        e = rq.pop_front();
        if ({r_s2m.rdata, r_s2m.rlast} !== e) begin
          bad++;
          $display("FAIL r_beat actual=%h/%b required=%h/%b", r_s2m.rdata, r_s2m.rlast,
                   e[32:1], e[0]);
        end
      end
    end
  end

  // B monitor: one response per issued write burst.
  always @(negedge clock) begin
    if (!reset && w_s2m.bvalid && w_m2s.bready) begin
      total++;
      if (bq.size() == 0) begin
        bad++;
        $display("FAIL b_resp actual=extra bvalid required=none pending");
      end else begin
        void'(bq.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void exp_r(input logic [31:0] d, input logic l);
    rq.push_back({d, l});
  endfunction

  // Wait for a ready/valid to be seen high at a negedge; returns just after the next posedge.
  task automatic hs_wait(input int sel, input string name);
    int   n;
    logic s;
    n = 0;
    do begin
      @(negedge clock);
      case (sel)
        0:       s = r_s2m.arready;
        1:       s = w_s2m.awready;
        2:       s = w_s2m.wready;
        default: s = w_s2m.bvalid;
      endcase
      @(posedge clock);
      #1;
      n++;
    end while (!s && n < 50);
    if (!s) begin
      total++;
      bad++;
      $display("FAIL %s actual=timeout required=handshake", name);
    end
  endtask

  task automatic wait_rvalid();
    int   lat;
    logic v;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
      v = r_s2m.rvalid;
      if (!v) begin
        @(posedge clock);
        #1;
      end
    end while (!v && lat < 50);
    chk("r_latency", 33'(lat), 33'(RespLat));
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int bwait,
                          input int early);
    bq.push_back(1'b1);
    w_m2s.awvalid = 1'b1;
    w_m2s.awaddr  = addr;
    w_m2s.awlen   = len;
    w_m2s.awsize  = 3'd2;
    w_m2s.awburst = BurstIncr;
    hs_wait(1, "aw_hs");
    w_m2s.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_m2s.wvalid = 1'b1;
      w_m2s.wdata  = wdat[i];
      w_m2s.wstrb  = wstb[i];
      w_m2s.wlast  = (i == int'(len)) || (i == early);
      hs_wait(2, "w_hs");
    end
    w_m2s.wvalid = 1'b0;
    w_m2s.wlast  = 1'b0;
    for (int k = 0; k < bwait; k++) begin
      @(negedge clock);
      chk("bvalid_hold", 33'(w_s2m.bvalid), 33'd1);
      @(posedge clock);
      #1;
    end
    w_m2s.bready = 1'b1;
    hs_wait(3, "b_hs");
    w_m2s.bready = 1'b0;
  endtask

  // Expected beats must be queued by the caller; toggle alternates rready 0/1.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic toggle);
    int          beats;
    int          cyc;
    logic        have_prev;
    logic [32:0] prev;
    r_m2s.rready  = 1'b0;
    r_m2s.arvalid = 1'b1;
    r_m2s.araddr  = addr;
    r_m2s.arlen   = len;
    r_m2s.arsize  = 3'd2;
    r_m2s.arburst = burst;
    hs_wait(0, "ar_hs");
    r_m2s.arvalid = 1'b0;
    wait_rvalid();
    beats     = 0;
    cyc       = 0;
    have_prev = 1'b0;
    prev      = '0;
    while (beats <= int'(len) && cyc < 200) begin
      r_m2s.rready = toggle ? (cyc % 2 == 1) : 1'b1;
      @(negedge clock);
      if (r_s2m.rvalid) begin
        if (have_prev) chk("r_stable", {r_s2m.rdata, r_s2m.rlast}, prev);
        if (r_m2s.rready) begin
          beats++;
          have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          prev      = {r_s2m.rdata, r_s2m.rlast};
        end
      end
      @(posedge clock);
      #1;
      cyc++;
    end
    r_m2s.rready = 1'b0;
    chk("r_beat_count", 33'(beats), 33'(int'(len) + 1));
    @(negedge clock);
    chk("r_idle_rvalid", 33'(r_s2m.rvalid), 33'd0);
    chk("r_idle_arready", 33'(r_s2m.arready), 33'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    r_m2s = '0;
    w_m2s = '0;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wdat[i] = '0;
      wstb[i] = 4'hF;
    end
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_arready", 33'(r_s2m.arready), 33'd1);
    chk("rst_awready", 33'(w_s2m.awready), 33'd1);
    chk("rst_rvalid", 33'(r_s2m.rvalid), 33'd0);
    chk("rst_rlast", 33'(r_s2m.rlast), 33'd0);
    chk("rst_rdata", 33'(r_s2m.rdata), 33'd0);
    chk("rst_wready", 33'(w_s2m.wready), 33'd0);
    chk("rst_bvalid", 33'(w_s2m.bvalid), 33'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // W offered before AW must stall.
    w_m2s.wvalid = 1'b1;
    @(negedge clock);
    chk("w_stall", 33'(w_s2m.wready), 33'd0);
    @(posedge clock);
    #1;

    wdat[0] = 32'hDEADBEEF;
    do_write(Base + 32'd8, 8'd0, 0, -1);
    exp_r(32'hDEADBEEF, 1'b1);
    do_read(Base + 32'd8, 8'd0, BurstIncr, 1'b0);

    for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
    do_write(Base, 8'd3, 0, -1);

    // Early wlast on beat 0 of a two-beat burst: both beats still land.
    wdat[0] = 32'h55;
    wdat[1] = 32'h66;
    do_write(Base + 32'h20, 8'd1, 0, 0);
    exp_r(32'h55, 1'b0);
    exp_r(32'h66, 1'b1);
    do_read(Base + 32'h20, 8'd1, BurstIncr, 1'b0);

    exp_r(32'd1, 1'b0);
    exp_r(32'd2, 1'b0);
    exp_r(32'd3, 1'b0);
    exp_r(32'd4, 1'b1);
    do_read(Base, 8'd3, BurstIncr, 1'b1);

    exp_r(32'd2, 1'b0);
    exp_r(32'd3, 1'b1);
    do_read(Base + 32'd4, 8'd1, BurstWrap, 1'b0);

    exp_r(32'd3, 1'b0);
    exp_r(32'd3, 1'b0);
    exp_r(32'd3, 1'b1);
    do_read(Base + 32'd8, 8'd2, BurstFixed, 1'b0);

    wdat[0] = 32'h11223344;
    wstb[0] = 4'hF;
    do_write(Base, 8'd0, 0, -1);
    wdat[0] = 32'hAABBCCDD;
    wstb[0] = 4'b0101;
    do_write(Base, 8'd0, 5, -1);
    wstb[0] = 4'hF;
    exp_r(32'h11BB33DD, 1'b1);
    do_read(Base, 8'd0, BurstIncr, 1'b0);

    exp_r(32'h0, 1'b1);
    do_read(Base + 32'(4 * Words), 8'd0, BurstIncr, 1'b0);
    exp_r(32'h0, 1'b1);
    do_read(Base - 32'd4, 8'd0, BurstIncr, 1'b0);
    wdat[0] = 32'hCAFEF00D;
    do_write(Base + 32'(4 * Words), 8'd0, 0, -1);
    exp_r(32'h11BB33DD, 1'b1);
    do_read(Base, 8'd0, BurstIncr, 1'b0);

    // Reset after two beats of an eight-beat read; remaining beats must never appear.
    exp_r(32'h11BB33DD, 1'b0);
    exp_r(32'd2, 1'b0);
    r_m2s.arvalid = 1'b1;
    r_m2s.araddr  = Base;
    r_m2s.arlen   = 8'd7;
    r_m2s.arburst = BurstIncr;
    hs_wait(0, "ar_rst_hs");
    r_m2s.arvalid = 1'b0;
    wait_rvalid();
    r_m2s.rready = 1'b1;
    repeat (2) begin
      @(negedge clock);
      @(posedge clock);
      #1;
    end
    r_m2s.rready = 1'b0;
    reset        = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_rvalid", 33'(r_s2m.rvalid), 33'd0);
    chk("rst_mid_arready", 33'(r_s2m.arready), 33'd1);
    chk("rst_mid_bvalid", 33'(w_s2m.bvalid), 33'd0);
    @(posedge clock);
    #1;
    exp_r(32'd3, 1'b1);
    do_read(Base + 32'd8, 8'd0, BurstIncr, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    chk("rq_empty", 33'(rq.size()), 33'd0);
    chk("bq_empty", 33'(bq.size()), 33'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
